hamming_encode_engine: RTL and testbench



---
 rtl/hamming_encode_engine.sv | 137 +++++++++++++
 tb/tb_hamming_encode_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encode_engine.sv
// SECDED encoder engine: reads NUM_WORDS 11-bit messages (two bytes each) from the
// shared byte-wide data memory and writes 16-bit Hamming+overall-parity codewords back.
// Ports: clk/reset, start pulse, mem_addr/mem_rd_data/mem_wr_en/mem_wr_data, busy, done.
// Latency: 4 cycles per word, done rises 4*NUM_WORDS+1 cycles after the start edge.
// Backpressure: none; start is ignored while busy, restarts the run from DONE.
module hamming_encode_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         lo_q, lo_d;
  logic [2:0]         hi_q, hi_d;

  logic [ADDR_W-1:0]  off;
  logic [ADDR_W-1:0]  src_a;
  logic [ADDR_W-1:0]  dst_a;
  logic               last;

  // dv[k-1] holds message bit d[k]
  logic [10:0]        dv;
  logic               p8, p4, p2, p1, p0;
  logic [15:0]        code;

  assign dv   = {hi_q, lo_q};
  assign p8   = ^dv[10:4];
  assign p4   = (^dv[10:7]) ^ (^dv[3:1]);
  assign p2   = dv[10] ^ dv[9] ^ dv[6] ^ dv[5] ^ dv[3] ^ dv[2] ^ dv[0];
  assign p1   = dv[10] ^ dv[8] ^ dv[6] ^ dv[4] ^ dv[3] ^ dv[1] ^ dv[0];
  assign p0   = (^dv) ^ p8 ^ p4 ^ p2 ^ p1;
  assign code = {dv[10:4], p8, dv[3:1], p4, dv[0], p2, p1, p0};

  // Byte offset of the current word; address arithmetic wraps at ADDR_W bits.
  assign off   = ADDR_W'({idx_q, 1'b0});
  assign src_a = ADDR_W'(SRC_BASE) + off;
  assign dst_a = ADDR_W'(DST_BASE) + off;
  assign last  = (idx_q == IDX_W'(NUM_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_LO;
          idx_d   = '0;
        end
      end
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_a;
        lo_d     = mem_rd_data;
        state_d  = RD_HI;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_a + ADDR_W'(1);
        // Upper five bits of the high byte are unused and dropped here.
        hi_d     = mem_rd_data[2:0];
        state_d  = WR_LO;
      end
      WR_LO: begin
        busy        = 1'b1;
        mem_addr    = dst_a;
        mem_wr_en   = 1'b1;
        mem_wr_data = code[7:0];
        state_d     = WR_HI;
      end
      WR_HI: begin
        busy        = 1'b1;
        mem_addr    = dst_a + ADDR_W'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = code[15:8];
        if (last) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_LO;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = RD_LO;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= 8'h00;
      hi_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_hamming_encode_engine.sv
// Bench for hamming_encode_engine: byte memory model, table vectors and random messages
// checked against a position-based Hamming reference, reset-abort and restart sequences.
module tb_hamming_encode_engine;

  localparam int NW  = 15;
  localparam int SRC = 0;
  localparam int DST = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  int         wr_cnt   = 0;
  int         stray_wr = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_encode_engine #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt = wr_cnt + 1;
      if (int'(mem_addr) < DST || int'(mem_addr) >= DST + 2 * NW) stray_wr = stray_wr + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference: classic Hamming placement, data in non-power-of-two positions 3..15,
  // parity at position 2^k covers every position with bit k set, bit 0 = overall parity.
  function automatic logic [15:0] ref_code(input logic [7:0] lo, input logic [7:0] hi);
    logic [10:0] m;
    logic [15:0] c;
    logic        x;
    int          k;
    m = {hi[2:0], lo};
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = m[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int pos = 1; pos < 16; pos++) if ((pos & p) != 0) x = x ^ c[pos];
      c[p] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic load(input int a, input logic [7:0] v);
    ld_addr = 8'(a);
    ld_data = v;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Pulses start, then counts cycles until done; optionally re-pulses start mid-run.
  task automatic run(input int glitch, output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_in_first_cycle", int'(busy), 1);
    while (!done && cyc < 500) begin
      start = (cyc == glitch);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [5];
  logic [7:0]  src_copy [2*NW];
  logic [15:0] first_out [NW];
  int          cyc;
  int          w0;
  int          found;
  logic [15:0] got;

  task automatic check_codes(input string tag);
    for (int i = 0; i < NW; i++) begin
      got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
      chk($sformatf("%s_code%0d", tag, i), int'(got),
          int'(ref_code(mem[SRC + 2*i], mem[SRC + 2*i + 1])));
    end
  endtask

  initial begin
    tbl[0] = '{"zero",    8'h00, 8'h00, 16'h0000};
    tbl[1] = '{"all_one", 8'hFF, 8'h07, 16'hFFFF};
    tbl[2] = '{"d1_only", 8'h01, 8'h00, 16'h000F};
    tbl[3] = '{"d11_only",8'h00, 8'h04, 16'h8117};
    tbl[4] = '{"garbage", 8'h00, 8'hF8, 16'h0000};

    reset = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_addr",  int'(mem_addr), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_wdata", int'(mem_wr_data), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    reset = 1'b0;
    @(negedge clk);

    // Run 1: table vectors in slots 0..4, random messages with random garbage elsewhere.
    for (int i = 0; i < NW; i++) begin
      if (i < 5) begin
        load(SRC + 2*i, tbl[i].lo);
        load(SRC + 2*i + 1, tbl[i].hi);
      end else begin
        load(SRC + 2*i, 8'($urandom));
        load(SRC + 2*i + 1, 8'($urandom));
      end
    end
    for (int a = DST; a < DST + 2*NW; a++) load(a, 8'hAA);
    for (int a = 0; a < 2*NW; a++) src_copy[a] = mem[SRC + a];

    w0 = wr_cnt;
    run(-1, cyc);
    chk("done_latency", cyc, 4*NW + 1);
    chk("done_high", int'(done), 1);
    chk("busy_low_in_done", int'(busy), 0);
    chk("wr_en_low_in_done", int'(mem_wr_en), 0);
    chk("write_strobes", wr_cnt - w0, 2*NW);
    chk("stray_writes", stray_wr, 0);
    for (int i = 0; i < 5; i++) begin
      got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
      chk($sformatf("tbl_%s", tbl[i].name), int'(got), int'(tbl[i].exp));
    end
    check_codes("run1");
    for (int a = 0; a < 2*NW; a++)
      chk($sformatf("src_kept%0d", a), int'(mem[SRC + a]), int'(src_copy[a]));
    for (int i = 0; i < NW; i++) first_out[i] = {mem[DST + 2*i + 1], mem[DST + 2*i]};

    // Run 2: restart from DONE over a scrubbed destination must reproduce run 1.
    for (int a = DST; a < DST + 2*NW; a++) load(a, 8'h55);
    chk("done_held", int'(done), 1);
    w0 = wr_cnt;
    run(-1, cyc);
    chk("rerun_latency", cyc, 4*NW + 1);
    chk("rerun_strobes", wr_cnt - w0, 2*NW);
    for (int i = 0; i < NW; i++) begin
      got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
      chk($sformatf("rerun_same%0d", i), int'(got), int'(first_out[i]));
    end

    // Abort: reset while the low byte of word 7 is being written.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (mem_wr_en && int'(mem_addr) == DST + 14) found = 1;
      else @(negedge clk);
    end
    chk("reached_wr_lo_word7", found, 1);
    reset = 1'b1;
    #1;
    chk("abort_addr",  int'(mem_addr), 0);
    chk("abort_wr_en", int'(mem_wr_en), 0);
    chk("abort_wdata", int'(mem_wr_data), 0);
    chk("abort_busy",  int'(busy), 0);
    chk("abort_done",  int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Run 3: fresh random data, extra start pulse mid-run must not disturb timing.
    for (int a = SRC; a < SRC + 2*NW; a++) load(a, 8'($urandom));
    w0 = wr_cnt;
    run(20, cyc);
    chk("glitch_latency", cyc, 4*NW + 1);
    chk("glitch_strobes", wr_cnt - w0, 2*NW);
    chk("stray_writes_end", stray_wr, 0);
    check_codes("run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
